crc14_checker: RTL and testbench

- Receive-side stage that consumes the 22-bit codeword produced by the CRC-14 encoder: {8-bit message, 14-bit CRC}.
- Recomputes the CRC bit-serially over the message, compares it with the received CRC, and reports pass/fail plus the syndrome.
- Sits directly downstream of the encoder, or after the channel model; its output feeds the message sink or the retransmit logic.

---
 rtl/crc14_pkg.sv | 17 +
 rtl/crc14_lfsr_step.sv | 18 +
 rtl/crc14_checker.sv | 117 +++++++++++
 tb/tb_crc14_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/crc14_pkg.sv
// Shared CRC-14 constants and checker state type. The encoder can import this package too.
package crc14_pkg;

  localparam int unsigned MSG_W = 8;
  localparam int unsigned CRC_W = 14;
  localparam int unsigned CW_W  = MSG_W + CRC_W;

  // x^14+x^10+x^8+x^7+x^4+x^3+1, with the implicit x^14 term dropped
  localparam logic [CRC_W-1:0] CRC14_POLY = 14'h0599;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } chk_state_e;

endpackage

// File: rtl/crc14_lfsr_step.sv
// One bit of a Galois-form CRC LFSR update: MSB-first, message bit XORed into the feedback.
module crc14_lfsr_step
  import crc14_pkg::*;
#(
  parameter int unsigned       CrcW = CRC_W,
  parameter logic [CrcW-1:0]   Poly = CRC14_POLY
) (
  input  logic [CrcW-1:0] lfsr_i,
  input  logic            din_i,
  output logic [CrcW-1:0] lfsr_o
);

  logic fb;

  assign fb     = din_i ^ lfsr_i[CrcW-1];
  assign lfsr_o = {lfsr_i[CrcW-2:0], 1'b0} ^ (fb ? Poly : '0);

endmodule

// File: rtl/crc14_checker.sv
// Bit-serial CRC-14 checker: recomputes the CRC over the 8-bit message and
// compares it with the received CRC, posting pass/fail and the syndrome.
module crc14_checker
  import crc14_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CW_W-1:0] data_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [MSG_W-1:0] data_out_o,
  output logic            crc_ok_o,
  output logic            crc_err_o,
  output logic [CRC_W-1:0] syndrome_o
);

  localparam int unsigned CntW = $clog2(MSG_W);

  chk_state_e       state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [MSG_W-1:0] data_out_q, data_out_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [CRC_W-1:0] syn_q, syn_d;
  logic [CRC_W-1:0] lfsr_next;

  crc14_lfsr_step #(
    .CrcW (CRC_W),
    .Poly (CRC14_POLY)
  ) u_lfsr_step (
    .lfsr_i (lfsr_q),
    .din_i  (msg_q[cnt_q]),
    .lfsr_o (lfsr_next)
  );

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    rx_crc_d   = rx_crc_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    ok_d       = ok_q;
    err_d      = err_q;
    syn_d      = syn_q;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (start_i) begin
          msg_d    = data_in_i[CW_W-1:CRC_W];
          rx_crc_d = data_in_i[CRC_W-1:0];
          lfsr_d   = '0;
          cnt_d    = CntW'(MSG_W - 1);
          state_d  = StShift;
        end
      end
      StShift: begin
        lfsr_d = lfsr_next;
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCheck: begin
        syn_d      = lfsr_q ^ rx_crc_q;
        data_out_d = msg_q;
        ok_d       = (lfsr_q == rx_crc_q);
        err_d      = (lfsr_q != rx_crc_q);
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      msg_q      <= '0;
      rx_crc_q   <= '0;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      syn_q      <= '0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      rx_crc_q   <= rx_crc_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      syn_q      <= syn_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign data_out_o = data_out_q;
  assign crc_ok_o   = ok_q;
  assign crc_err_o  = err_q;
  assign syndrome_o = syn_q;

endmodule

// File: tb/tb_crc14_checker.sv
// Self-checking bench for crc14_checker: directed vector table, multi-cycle corner
// sequences, and a random codeword stream against a polynomial-division model.
module tb_crc14_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [21:0] data_in;
  logic        busy;
  logic        done;
  logic [7:0]  data_out;
  logic        crc_ok;
  logic        crc_err;
  logic [13:0] syndrome;

  int pass_cnt = 0;
  int total_cnt = 0;

  crc14_checker dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .data_in_i  (data_in),
    .busy_o     (busy),
    .done_o     (done),
    .data_out_o (data_out),
    .crc_ok_o   (crc_ok),
    .crc_err_o  (crc_err),
    .syndrome_o (syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Remainder of msg(x)*x^14 divided by the full generator 0x4599, by long division.
  function automatic logic [13:0] ref_crc(input logic [7:0] msg);
    logic [21:0] r;
    logic [21:0] g;
    r = {msg, 14'h0};
    for (int i = 21; i >= 14; i--) begin
      if (r[i]) begin
        g = 22'h004599 << (i - 14);
        r = r ^ g;
      end
    end
    return r[13:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive start for one cycle; returns at the negedge after the sampling edge.
  task automatic start_cw(input logic [21:0] cw);
    @(negedge clk);
    data_in = cw;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded), and busy cycles including the current one.
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = busy ? 1 : 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
    end while (!done && n < 30);
  endtask

  task automatic chk_result(input string name, input logic ok, input logic [13:0] syn,
                            input logic [7:0] dout);
    chk({name, ".ok"}, {31'h0, crc_ok}, {31'h0, ok});
    chk({name, ".err"}, {31'h0, crc_err}, {31'h0, ~ok});
    chk({name, ".syn"}, {18'h0, syndrome}, {18'h0, syn});
    chk({name, ".dout"}, {24'h0, data_out}, {24'h0, dout});
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {19'h0, busy, done, data_out, crc_ok, crc_err, syndrome}, 32'h0);
  endtask

  typedef struct {
    logic [21:0] cw;
    logic        ok;
    logic [13:0] syn;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, bc, ndone;
    logic [7:0]  msg;
    logic [13:0] crc, exp_syn;
    logic [21:0] cw, mask;

    vecs[0] = '{cw: 22'h000000, ok: 1'b1, syn: 14'h0000, dout: 8'h00};
    vecs[1] = '{cw: 22'h004599, ok: 1'b1, syn: 14'h0000, dout: 8'h01};
    vecs[2] = '{cw: 22'h202EE3, ok: 1'b1, syn: 14'h0000, dout: 8'h80};
    vecs[3] = '{cw: 22'h202EE2, ok: 1'b0, syn: 14'h0001, dout: 8'h80};
    vecs[4] = '{cw: 22'h000599, ok: 1'b0, syn: 14'h0599, dout: 8'h00};

    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset_state");

    // Directed table, with latency and busy length checked on each entry
    for (int i = 0; i < 5; i++) begin
      start_cw(vecs[i].cw);
      wait_done(n, bc);
      chk($sformatf("vec%0d.latency", i), n, 9);
      chk($sformatf("vec%0d.busy_cycles", i), bc, 9);
      chk_result($sformatf("vec%0d", i), vecs[i].ok, vecs[i].syn, vecs[i].dout);
      @(negedge clk);
      chk($sformatf("vec%0d.done_pulse", i), {31'h0, done}, 32'h0);
    end

    // Start pulses while busy must be ignored
    start_cw(22'h004599);
    n = 0;
    ndone = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2 || n == 4) begin
        data_in = 22'h000001;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < 30);
    chk("ignore.latency", n, 9);
    chk_result("ignore", 1'b1, 14'h0000, 8'h01);
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignore.no_extra_done", ndone, 0);

    // Back-to-back: start presented during the done cycle
    start_cw(22'h202EE3);
    wait_done(n, bc);
    chk("b2b.first_latency", n, 9);
    data_in = 22'h202EE2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.done_spacing", n, 10);
    chk_result("b2b", 1'b0, 14'h0001, 8'h80);

    // Reset during the 4th shift: no done, outputs cleared, then recovery
    start_cw(22'h202EE2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midreset.cleared");
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset.no_done", ndone, 0);
    start_cw(22'h202EE3);
    wait_done(n, bc);
    chk("midreset.recover_latency", n, 9);
    chk_result("midreset.recover", 1'b1, 14'h0000, 8'h80);

    // Random stream with ~30% corrupted codewords
    for (int k = 0; k < 1000; k++) begin
      msg = 8'($urandom);
      cw = {msg, ref_crc(msg)};
      if ($urandom_range(99) < 30) begin
        if ($urandom_range(1) == 0) mask = 22'h1 << $urandom_range(21);
        else mask = 22'($urandom) | 22'h1;
        cw = cw ^ mask;
      end
      crc = ref_crc(cw[21:14]);
      exp_syn = crc ^ cw[13:0];
      start_cw(cw);
      wait_done(n, bc);
      chk($sformatf("rand%0d.latency", k), n, 9);
      chk_result($sformatf("rand%0d", k), (exp_syn == 14'h0), exp_syn, cw[21:14]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
